// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared encodings for the AXI-Lite command master: FSM states, AXI response codes
// and downstream target selects.
package axi_lite_cmd_master_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_WADDR_DATA = 3'd1;
   localparam state_t ST_WRESP      = 3'd2;
   localparam state_t ST_RADDR      = 3'd3;
   localparam state_t ST_RDATA      = 3'd4;
   localparam state_t ST_RSP        = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] TGT_SHA256  = 2'b00;
   localparam logic [1:0] TGT_AES_CTR = 2'b01;
   localparam logic [1:0] TGT_PIC     = 2'b10;
   localparam logic [1:0] TGT_NONE    = 2'b11;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// Command, response and AXI-Lite master channel signals of the command master.
// The master modport is the block's view; the slave modport is the environment's.
interface axi_lite_cmd_master_if;

   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [1:0]  cmd_target_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [3:0]  cmd_wstrb_i;

   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_resp_o;

   logic [1:0]  target_selector_o;

   logic [31:0] write_addr_o;
   logic [2:0]  write_prot_o;
   logic        write_addr_valid_o;
   logic        write_addr_ready_i;
   logic [31:0] write_data_o;
   logic [3:0]  write_strb_o;
   logic        write_data_valid_o;
   logic        write_data_ready_i;
   logic [1:0]  write_resp_i;
   logic        write_resp_valid_i;
   logic        write_resp_ready_o;

   logic [31:0] read_addr_o;
   logic [2:0]  read_prot_o;
   logic        read_addr_valid_o;
   logic        read_addr_ready_i;
   logic [31:0] read_data_i;
   logic [1:0]  read_resp_i;
   logic        read_data_valid_i;
   logic        read_data_ready_o;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_target_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_resp_o,
      input  rsp_ready_i,
      output target_selector_o,
      output write_addr_o, write_prot_o, write_addr_valid_o,
      input  write_addr_ready_i,
      output write_data_o, write_strb_o, write_data_valid_o,
      input  write_data_ready_i,
      input  write_resp_i, write_resp_valid_i,
      output write_resp_ready_o,
      output read_addr_o, read_prot_o, read_addr_valid_o,
      input  read_addr_ready_i,
      input  read_data_i, read_resp_i, read_data_valid_i,
      output read_data_ready_o
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_target_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_resp_o,
      output rsp_ready_i,
      input  target_selector_o,
      input  write_addr_o, write_prot_o, write_addr_valid_o,
      output write_addr_ready_i,
      input  write_data_o, write_strb_o, write_data_valid_o,
      output write_data_ready_i,
      output write_resp_i, write_resp_valid_i,
      input  write_resp_ready_o,
      input  read_addr_o, read_prot_o, read_addr_valid_o,
      output read_addr_ready_i,
      output read_data_i, read_resp_i, read_data_valid_i,
      input  read_data_ready_o
   );

endinterface

// File: rtl/axi_lite_cmd_master_timeout_ctr.sv
// Wait-cycle counter: cleared on entry to each waiting state, counts while enabled,
// and flags expiry on the last allowed waiting cycle.
module axi_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_srst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_srst || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into an AW/W/B or AR/R
// exchange on the selected target and returns one response.
module axi_lite_cmd_master
   import axi_lite_cmd_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                   clk_i,
   input logic                   rst_i,
   axi_lite_cmd_master_if.master bus
);

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_target;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_aw_valid;
   logic        r_w_valid;
   logic [31:0] r_rsp_rdata;
   logic [1:0]  r_rsp_resp;

   logic w_aw_done;
   logic w_w_done;
   logic w_waiting;
   logic w_ctr_clear;
   logic w_expired;

   // A channel counts as done once its valid has dropped or it handshakes this cycle.
   assign w_aw_done = !r_aw_valid || bus.write_addr_ready_i;
   assign w_w_done  = !r_w_valid  || bus.write_data_ready_i;

   assign w_waiting = (r_state == ST_WADDR_DATA) || (r_state == ST_WRESP) ||
                      (r_state == ST_RADDR)      || (r_state == ST_RDATA);
   assign w_ctr_clear = !w_waiting || (w_state_next != r_state);

   axi_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk     (clk_i),
      .i_srst    (rst_i),
      .i_clear   (w_ctr_clear),
      .i_enable  (w_waiting),
      .o_expired (w_expired)
   );

   // A handshake landing on the expiry cycle still completes normally.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid_i) begin
               if (bus.cmd_target_i == TGT_NONE) w_state_next = ST_RSP;
               else if (bus.cmd_write_i)         w_state_next = ST_WADDR_DATA;
               else                              w_state_next = ST_RADDR;
            end
         end
         ST_WADDR_DATA: begin
            if (w_aw_done && w_w_done) w_state_next = ST_WRESP;
            else if (w_expired)        w_state_next = ST_RSP;
         end
         ST_WRESP: begin
            if (bus.write_resp_valid_i || w_expired) w_state_next = ST_RSP;
         end
         ST_RADDR: begin
            if (bus.read_addr_ready_i) w_state_next = ST_RDATA;
            else if (w_expired)        w_state_next = ST_RSP;
         end
         ST_RDATA: begin
            if (bus.read_data_valid_i || w_expired) w_state_next = ST_RSP;
         end
         ST_RSP: begin
            if (bus.rsp_ready_i) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_target    <= TGT_NONE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_aw_valid  <= 1'b0;
         r_w_valid   <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= RESP_OKAY;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid_i) begin
                  r_target <= bus.cmd_target_i;
                  r_addr   <= bus.cmd_addr_i;
                  r_wdata  <= bus.cmd_wdata_i;
                  r_wstrb  <= bus.cmd_wstrb_i;
                  if (bus.cmd_target_i == TGT_NONE) begin
                     r_rsp_resp  <= RESP_DECERR;
                     r_rsp_rdata <= '0;
                  end else if (bus.cmd_write_i) begin
                     r_aw_valid <= 1'b1;
                     r_w_valid  <= 1'b1;
                  end
               end
            end
            ST_WADDR_DATA: begin
               if (w_aw_done && w_w_done) begin
                  r_aw_valid <= 1'b0;
                  r_w_valid  <= 1'b0;
               end else if (w_expired) begin
                  r_aw_valid  <= 1'b0;
                  r_w_valid   <= 1'b0;
                  r_rsp_resp  <= RESP_DECERR;
                  r_rsp_rdata <= '0;
               end else begin
                  if (bus.write_addr_ready_i) r_aw_valid <= 1'b0;
                  if (bus.write_data_ready_i) r_w_valid  <= 1'b0;
               end
            end
            ST_WRESP: begin
               if (bus.write_resp_valid_i) begin
                  r_rsp_resp  <= bus.write_resp_i;
                  r_rsp_rdata <= '0;
               end else if (w_expired) begin
                  r_rsp_resp  <= RESP_DECERR;
                  r_rsp_rdata <= '0;
               end
            end
            ST_RADDR: begin
               if (!bus.read_addr_ready_i && w_expired) begin
                  r_rsp_resp  <= RESP_DECERR;
                  r_rsp_rdata <= '0;
               end
            end
            ST_RDATA: begin
               if (bus.read_data_valid_i) begin
                  r_rsp_resp  <= bus.read_resp_i;
                  r_rsp_rdata <= bus.read_data_i;
               end else if (w_expired) begin
                  r_rsp_resp  <= RESP_DECERR;
                  r_rsp_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready_o        = (r_state == ST_IDLE);
   assign bus.rsp_valid_o        = (r_state == ST_RSP);
   assign bus.rsp_rdata_o        = r_rsp_rdata;
   assign bus.rsp_resp_o         = r_rsp_resp;
   assign bus.target_selector_o  = r_target;

   assign bus.write_addr_o       = r_addr;
   assign bus.write_prot_o       = 3'b000;
   assign bus.write_addr_valid_o = r_aw_valid;
   assign bus.write_data_o       = r_wdata;
   assign bus.write_strb_o       = r_wstrb;
   assign bus.write_data_valid_o = r_w_valid;
   assign bus.write_resp_ready_o = (r_state == ST_WRESP);

   // Read address valid and both readys follow the state, so leaving it drops them.
   assign bus.read_addr_o        = r_addr;
   assign bus.read_prot_o        = 3'b000;
   assign bus.read_addr_valid_o  = (r_state == ST_RADDR);
   assign bus.read_data_ready_o  = (r_state == ST_RDATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: table of command/slave-behaviour vectors
// plus hand sequences for same-cycle handshakes, timeout timing, target 11 and reset.
module tb_axi_lite_cmd_master;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   axi_lite_cmd_master_if bus ();

   axi_lite_cmd_master #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Slave behaviour knobs, written by the main sequence only
   bit          slv_en = 1'b0;
   int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
   logic [1:0]  s_resp = 2'b00;
   logic [31:0] s_rdata = 32'h0;

   int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

   always @(negedge clk) begin
      if (!slv_en) begin
         bus.write_addr_ready_i = 1'b0;
         bus.write_data_ready_i = 1'b0;
         bus.write_resp_valid_i = 1'b0;
         bus.write_resp_i       = 2'b00;
         bus.read_addr_ready_i  = 1'b0;
         bus.read_data_valid_i  = 1'b0;
         bus.read_data_i        = 32'h0;
         bus.read_resp_i        = 2'b00;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
         if (bus.write_addr_valid_o) begin
            bus.write_addr_ready_i = (aw_cnt >= aw_lat); aw_cnt++;
         end else begin
            bus.write_addr_ready_i = 1'b0; aw_cnt = 0;
         end
         if (bus.write_data_valid_o) begin
            bus.write_data_ready_i = (w_cnt >= w_lat); w_cnt++;
         end else begin
            bus.write_data_ready_i = 1'b0; w_cnt = 0;
         end
         if (bus.write_resp_ready_o) begin
            bus.write_resp_valid_i = (b_cnt >= b_lat);
            bus.write_resp_i       = (b_cnt >= b_lat) ? s_resp : 2'b00;
            b_cnt++;
         end else begin
            bus.write_resp_valid_i = 1'b0; bus.write_resp_i = 2'b00; b_cnt = 0;
         end
         if (bus.read_addr_valid_o) begin
            bus.read_addr_ready_i = (ar_cnt >= ar_lat); ar_cnt++;
         end else begin
            bus.read_addr_ready_i = 1'b0; ar_cnt = 0;
         end
         if (bus.read_data_ready_o) begin
            bus.read_data_valid_i = (r_cnt >= r_lat);
            bus.read_data_i       = (r_cnt >= r_lat) ? s_rdata : 32'h0;
            bus.read_resp_i       = (r_cnt >= r_lat) ? s_resp : 2'b00;
            r_cnt++;
         end else begin
            bus.read_data_valid_i = 1'b0; bus.read_data_i = 32'h0;
            bus.read_resp_i = 2'b00; r_cnt = 0;
         end
      end
   end

   // Handshake counters and captured payloads, sampled on the active edge
   int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb = '0;
   logic [2:0]  cap_prot = '0;

   always @(posedge clk) begin
      if (bus.write_addr_valid_o && bus.write_addr_ready_i) begin
         aw_hs <= aw_hs + 1; cap_awaddr <= bus.write_addr_o; cap_prot <= bus.write_prot_o;
      end
      if (bus.write_data_valid_o && bus.write_data_ready_i) begin
         w_hs <= w_hs + 1; cap_wdata <= bus.write_data_o; cap_wstrb <= bus.write_strb_o;
      end
      if (bus.write_resp_ready_o && bus.write_resp_valid_i) b_hs <= b_hs + 1;
      if (bus.read_addr_valid_o && bus.read_addr_ready_i) begin
         ar_hs <= ar_hs + 1; cap_araddr <= bus.read_addr_o;
      end
      if (bus.read_data_ready_o && bus.read_data_valid_i) r_hs <= r_hs + 1;
   end

   // target_selector_o must hold its accepted value for the whole transaction
   bit         mon_en = 1'b0;
   logic [1:0] exp_tsel = 2'b11;
   int         tsel_err = 0;
   always @(negedge clk) begin
      if (mon_en && bus.target_selector_o !== exp_tsel) tsel_err++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the first cycle after accept
   task automatic send_cmd(input logic wr, input logic [1:0] tgt, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
      int n = 0;
      while (!bus.cmd_ready_o && n < 50) begin
         @(negedge clk); n++;
      end
      chk("cmd_ready_wait", {31'b0, bus.cmd_ready_o}, 32'h1);
      bus.cmd_valid_i  = 1'b1;
      bus.cmd_write_i  = wr;
      bus.cmd_target_i = tgt;
      bus.cmd_addr_i   = addr;
      bus.cmd_wdata_i  = wdata;
      bus.cmd_wstrb_i  = strb;
      @(negedge clk);
      bus.cmd_valid_i  = 1'b0;
   endtask

   task automatic wait_rsp(input int max_cycles, output int n);
      n = 0;
      while (!bus.rsp_valid_o && n < max_cycles) begin
         @(negedge clk); n++;
      end
   endtask

   task automatic finish_rsp(input string tag);
      bus.rsp_ready_i = 1'b1;
      chk({tag, "_no_accept_in_rsp"}, {31'b0, bus.cmd_ready_o}, 32'h0);
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      chk({tag, "_rsp_dropped"}, {31'b0, bus.rsp_valid_o}, 32'h0);
      chk({tag, "_back_idle"}, {31'b0, bus.cmd_ready_o}, 32'h1);
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  tgt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      bit          en;
      int          awl, wl, bl, arl, rl;
      logic [1:0]  sresp;
      logic [31:0] srdata;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_aw, exp_w, exp_ar;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int bad;
      int aw0, w0, ar0, b0, r0, te0;
      logic [1:0]  hold_resp;
      logic [31:0] hold_rdata;

      //            wr    tgt    addr          wdata         strb  en awl wl bl arl rl  sresp  srdata        exp_resp exp_rdata   aw w ar
      vecs[0] = '{1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 2, 1, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         1, 1, 0};
      vecs[1] = '{1'b0, 2'b01, 32'h0000_0004, 32'h0,         4'h0, 1, 0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 2'b00, 32'h1234_5678, 0, 0, 1};
      vecs[2] = '{1'b1, 2'b10, 32'h0000_0020, 32'hA5A5_0000, 4'h3, 1, 0, 0, 0, 0, 0, 2'b10, 32'h0,         2'b10, 32'h0,         1, 1, 0};
      vecs[3] = '{1'b0, 2'b00, 32'h0000_0008, 32'h0,         4'h0, 1, 0, 0, 0, 2, 0, 2'b10, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D, 0, 0, 1};
      vecs[4] = '{1'b1, 2'b01, 32'h0000_0044, 32'h0102_0304, 4'h9, 1, 3, 0, 2, 0, 0, 2'b00, 32'h0,         2'b00, 32'h0,         1, 1, 0};
      vecs[5] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0,         4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF, 2'b11, 32'h0,         0, 0, 0};
      vecs[6] = '{1'b1, 2'b10, 32'h0000_0200, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b11, 32'h0,         0, 0, 0};
      vecs[7] = '{1'b0, 2'b01, 32'h0000_0300, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b11, 32'h0,         0, 0, 0};

      rst_i = 1'b1;
      bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_target_i = 2'b00;
      bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0; bus.cmd_wstrb_i = '0;
      bus.rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
      chk("rst_tsel", {30'b0, bus.target_selector_o}, 32'h3);
      chk("rst_rsp_resp", {30'b0, bus.rsp_resp_o}, 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'h0);
      chk("rst_valids", {28'b0, bus.write_addr_valid_o, bus.write_data_valid_o,
                         bus.read_addr_valid_o, bus.read_data_ready_o}, 32'h0);
      chk("rst_bready", {31'b0, bus.write_resp_ready_o}, 32'h0);
      chk("rst_addr_data", bus.write_addr_o | bus.write_data_o | bus.read_addr_o, 32'h0);
      rst_i = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", {31'b0, bus.cmd_ready_o}, 32'h1);

      // Table-driven transactions
      for (int i = 0; i < 8; i++) begin
         slv_en = vecs[i].en;
         aw_lat = vecs[i].awl; w_lat = vecs[i].wl; b_lat = vecs[i].bl;
         ar_lat = vecs[i].arl; r_lat = vecs[i].rl;
         s_resp = vecs[i].sresp; s_rdata = vecs[i].srdata;
         aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; te0 = tsel_err;
         exp_tsel = vecs[i].tgt;
         send_cmd(vecs[i].wr, vecs[i].tgt, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         mon_en = 1'b1;
         wait_rsp(200, n);
         chk($sformatf("v%0d_rsp_valid", i), {31'b0, bus.rsp_valid_o}, 32'h1);
         chk($sformatf("v%0d_resp", i), {30'b0, bus.rsp_resp_o}, {30'b0, vecs[i].exp_resp});
         chk($sformatf("v%0d_rdata", i), bus.rsp_rdata_o, vecs[i].exp_rdata);
         chk($sformatf("v%0d_aw_hs", i), aw_hs - aw0, vecs[i].exp_aw);
         chk($sformatf("v%0d_w_hs", i), w_hs - w0, vecs[i].exp_w);
         chk($sformatf("v%0d_ar_hs", i), ar_hs - ar0, vecs[i].exp_ar);
         if (vecs[i].exp_aw > 0) begin
            chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].addr);
            chk($sformatf("v%0d_awprot", i), {29'b0, cap_prot}, 32'h0);
         end
         if (vecs[i].exp_w > 0) begin
            chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_wstrb", i), {28'b0, cap_wstrb}, {28'b0, vecs[i].strb});
         end
         if (vecs[i].exp_ar > 0)
            chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].addr);
         finish_rsp($sformatf("v%0d", i));
         mon_en = 1'b0;
         chk($sformatf("v%0d_tsel_stable", i), tsel_err - te0, 32'h0);
         @(negedge clk);
      end

      // AW and W ready in the valid cycle: WRESP the next cycle, no repeated valids
      slv_en = 1'b1; aw_lat = 0; w_lat = 0; b_lat = 2; s_resp = 2'b00;
      aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
      send_cmd(1'b1, 2'b00, 32'h0000_0050, 32'h1111_2222, 4'hF);
      chk("same_cyc_valids_up", {30'b0, bus.write_addr_valid_o, bus.write_data_valid_o}, 32'h3);
      @(negedge clk);
      chk("same_cyc_valids_down", {30'b0, bus.write_addr_valid_o, bus.write_data_valid_o}, 32'h0);
      chk("same_cyc_wresp", {31'b0, bus.write_resp_ready_o}, 32'h1);
      chk("same_cyc_hs", (aw_hs - aw0) * 16 + (w_hs - w0), 32'h11);
      wait_rsp(20, n);
      chk("same_cyc_b_hs", b_hs - b0, 32'h1);
      chk("same_cyc_resp", {30'b0, bus.rsp_resp_o}, 32'h0);
      finish_rsp("same_cyc");

      // Silent slave: abort exactly 16 cycles after the valids rise
      slv_en = 1'b0;
      send_cmd(1'b1, 2'b01, 32'h0000_0060, 32'h0BAD_F00D, 4'hF);
      chk("tmo_valid_up", {30'b0, bus.write_addr_valid_o, bus.write_data_valid_o}, 32'h3);
      wait_rsp(40, n);
      chk("tmo_latency", n, 32'd16);
      chk("tmo_valids_low", {28'b0, bus.write_addr_valid_o, bus.write_data_valid_o,
                             bus.read_addr_valid_o, bus.write_resp_ready_o}, 32'h0);
      chk("tmo_resp", {30'b0, bus.rsp_resp_o}, 32'h3);
      finish_rsp("tmo");

      // Target 11: no AXI activity, DECERR, payload held while rsp_ready is low
      slv_en = 1'b1;
      aw0 = aw_hs; ar0 = ar_hs;
      send_cmd(1'b1, 2'b11, 32'h0000_0070, 32'h7777_7777, 4'hF);
      chk("none_no_valids_a1", {30'b0, bus.write_addr_valid_o, bus.read_addr_valid_o}, 32'h0);
      @(negedge clk);
      chk("none_rsp_valid_a2", {31'b0, bus.rsp_valid_o}, 32'h1);
      chk("none_resp_a2", {30'b0, bus.rsp_resp_o}, 32'h3);
      hold_resp = bus.rsp_resp_o; hold_rdata = bus.rsp_rdata_o;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!bus.rsp_valid_o || bus.rsp_resp_o !== hold_resp || bus.rsp_rdata_o !== hold_rdata ||
             bus.write_addr_valid_o || bus.write_data_valid_o || bus.read_addr_valid_o)
            bad++;
      end
      chk("none_rsp_hold", bad, 32'h0);
      chk("none_no_hs", (aw_hs - aw0) + (ar_hs - ar0), 32'h0);
      finish_rsp("none");

      // Reset during RDATA: transaction abandoned, no response
      slv_en = 1'b1; ar_lat = 0; r_lat = 1000;
      send_cmd(1'b0, 2'b10, 32'h0000_0080, 32'h0, 4'h0);
      n = 0;
      while (!bus.read_data_ready_o && n < 20) begin
         @(negedge clk); n++;
      end
      chk("rst_mid_in_rdata", {31'b0, bus.read_data_ready_o}, 32'h1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("rst_mid_readys", {29'b0, bus.read_data_ready_o, bus.read_addr_valid_o, bus.rsp_valid_o}, 32'h0);
      chk("rst_mid_tsel", {30'b0, bus.target_selector_o}, 32'h3);
      chk("rst_mid_addr", bus.read_addr_o, 32'h0);
      chk("rst_mid_rsp", {bus.rsp_rdata_o[29:0], bus.rsp_resp_o}, 32'h0);
      rst_i = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.rsp_valid_o || !bus.cmd_ready_o) bad++;
      end
      chk("rst_mid_no_rsp", bad, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
